// File: rtl/cpu_instr_sequencer.sv
// Instruction sequencer for the cpu core: loads a program into a local buffer,
// issues it one instruction at a time (1 or 2 cycles each) and captures cpu results.
module cpu_instr_sequencer #(
  parameter int          DEPTH        = 16,
  parameter int          AW           = 4,
  parameter logic [15:0] TWO_CYC_MASK = 16'h15C0,
  parameter logic [7:0]  IDLE_INSTR   = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic [7:0]    cpu_out,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    instr,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   issued,
  output logic [7:0]    rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_FIN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [7:0] prog_mem [DEPTH];
  logic [7:0] res_mem  [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   issued_q, issued_d;
  logic [7:0]    cur_instr;
  logic [AW:0]   start_len;
  logic          res_we;

  function automatic logic is_two_cyc(input logic [3:0] opc);
    return TWO_CYC_MASK[opc];
  endfunction

  function automatic logic [AW:0] clamp_len(input logic [AW:0] n);
    return (n > DEPTH_L) ? DEPTH_L : n;
  endfunction

  assign cur_instr = prog_mem[ptr_q];
  assign start_len = clamp_len(prog_len);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    issued_d = issued_q;
    instr    = IDLE_INSTR;
    busy     = 1'b0;
    done     = 1'b0;
    res_we   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d    = start_len;
          ptr_d    = '0;
          issued_d = '0;
          state_d  = (start_len == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        instr = cur_instr;
        busy  = 1'b1;
        if (is_two_cyc(cur_instr[7:4])) state_d = S_HOLD;
        else                            res_we  = 1'b1;
      end
      S_HOLD: begin
        instr  = cur_instr;
        busy   = 1'b1;
        res_we = 1'b1;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Instruction end: record completion and advance or finish
    if (res_we) begin
      issued_d = {1'b0, ptr_q} + ONE_L;
      if ({1'b0, ptr_q} == len_q - ONE_L) begin
        state_d = S_FIN;
      end else begin
        ptr_d   = ptr_q + 1'b1;
        state_d = S_ISSUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      len_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
    end
  end

  // Buffers are never cleared; writes are blocked during reset and while issuing
  always_ff @(posedge clk) begin
    if (!reset && wr_en && !busy) prog_mem[wr_addr] <= wr_data;
    if (!reset && res_we)         res_mem[ptr_q]    <= cpu_out;
  end

  assign issued  = issued_q;
  assign rd_data = res_mem[rd_addr];

endmodule
